// File: rtl/register_bank_pkg.sv
// Shared types and default sizing for the datapath register bank.
// No logic; imported by the bank, its clear controller and its bus interface.
// Default WIDTH/DEPTH are the values the datapath instances use.
package register_bank_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int RB_WIDTH = 32;
    localparam int RB_DEPTH = 32;

endpackage

// File: rtl/register_bank_if.sv
// Decoder/writeback-facing bus of the register bank: write port, two read ports, busy.
// Pure wiring; timing is set by register_bank.
// No backpressure beyond busy, which drops writes while the clear runs.
interface register_bank_if
    import register_bank_pkg::*;
#(
    parameter int WIDTH = RB_WIDTH,
    parameter int AW    = $clog2(RB_DEPTH)
);
    logic             regen;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] wd;
    logic [AW-1:0]    rr1;
    logic [AW-1:0]    rr2;
    logic [WIDTH-1:0] dr1;
    logic [WIDTH-1:0] dr2;
    logic             busy;

    modport master (
        output regen, wa, wd, rr1, rr2,
        input  dr1, dr2, busy
    );

    modport slave (
        input  regen, wa, wd, rr1, rr2,
        output dr1, dr2, busy
    );
endinterface

// File: rtl/register_bank_clear_ctrl.sv
// Post-reset clear sequencer: walks every bank address once, then enters READY.
// Latency: busy stays high for DEPTH edges after reset release, falls on the next.
// Backpressure: none accepted; a reset mid-sequence restarts the walk from 0.
module register_bank_clear_ctrl
    import register_bank_pkg::*;
#(
    parameter  int DEPTH = RB_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          busy,
    output logic [AW-1:0] clr_addr,
    output logic          clr_we
);

    // One extra index value marks "all addresses written" so busy drops an edge later.
    localparam logic [AW:0] DONE_IDX = (AW + 1)'(DEPTH);

    state_e      state_q, state_d;
    logic [AW:0] idx_q, idx_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        clr_we  = 1'b0;
        case (state_q)
            CLEAR: begin
                if (idx_q == DONE_IDX) begin
                    state_d = READY;
                end else begin
                    clr_we = 1'b1;
                    idx_d  = idx_q + 1'b1;
                end
            end
            READY:   state_d = READY;
            default: state_d = CLEAR;
        endcase
    end

    assign busy     = (state_q == CLEAR);
    assign clr_addr = idx_q[AW-1:0];

endmodule

// File: rtl/register_bank.sv
// General-purpose register bank: one sync write port, two registered read ports, REGISTER_BANK_BYPASS_EN forwards same-edge writes.
// Latency: read 1 cycle; write visible 2 edges after request (1 with REGISTER_BANK_BYPASS_EN).
// Backpressure: none; writes dropped and reads return 0 while busy (post-reset clear).
module register_bank
    import register_bank_pkg::*;
#(
    parameter  int WIDTH    = RB_WIDTH,
    parameter  int DEPTH    = RB_DEPTH,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    register_bank_if.slave bus
);

    logic [WIDTH-1:0] bank [DEPTH];
    logic [WIDTH-1:0] dr1_q, dr2_q;
    logic [WIDTH-1:0] rd1_d, rd2_d;
    logic             busy;
    logic [AW-1:0]    clr_addr;
    logic             clr_we;
    logic             wr_ok;

    register_bank_clear_ctrl #(
        .DEPTH (DEPTH)
    ) u_clear_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .busy     (busy),
        .clr_addr (clr_addr),
        .clr_we   (clr_we)
    );

    assign wr_ok = bus.regen && !busy && !((ZERO_REG != 0) && (bus.wa == '0));

    // Storage carries no reset: contents are defined by the clear walk instead.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (clr_we) begin
                bank[clr_addr] <= '0;
            end else if (wr_ok) begin
                bank[bus.wa] <= bus.wd;
            end
        end
    end

    always_comb begin
        rd1_d = bank[bus.rr1];
        rd2_d = bank[bus.rr2];
`ifdef REGISTER_BANK_BYPASS_EN
        if (wr_ok && (bus.wa == bus.rr1)) rd1_d = bus.wd;
        if (wr_ok && (bus.wa == bus.rr2)) rd2_d = bus.wd;
`endif
        if ((ZERO_REG != 0) && (bus.rr1 == '0)) rd1_d = '0;
        if ((ZERO_REG != 0) && (bus.rr2 == '0)) rd2_d = '0;
        if (busy) begin
            rd1_d = '0;
            rd2_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dr1_q <= '0;
            dr2_q <= '0;
        end else begin
            dr1_q <= rd1_d;
            dr2_q <= rd2_d;
        end
    end

    assign bus.dr1  = dr1_q;
    assign bus.dr2  = dr2_q;
    assign bus.busy = busy;

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: ZERO_REG=1 and ZERO_REG=0 instances share one stimulus stream,
// checked every cycle against an array-based model of the bank (honours REGISTER_BANK_BYPASS_EN).
module tb_register_bank;
    import register_bank_pkg::*;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int AW = $clog2(D);
`ifdef REGISTER_BANK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst_n;

    register_bank_if #(.WIDTH(W), .AW(AW)) b1 ();
    register_bank_if #(.WIDTH(W), .AW(AW)) b0 ();

    register_bank #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    register_bank #(.WIDTH(W), .DEPTH(D), .ZERO_REG(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));

    assign b0.regen = b1.regen;
    assign b0.wa    = b1.wa;
    assign b0.wd    = b1.wd;
    assign b0.rr1   = b1.rr1;
    assign b0.rr2   = b1.rr2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int stepno = 0;

    logic [W-1:0] m1 [D];
    logic [W-1:0] m0 [D];
    int           edges_since_rst;
    logic [W-1:0] e11, e21, e10, e20;
    logic         ebusy;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step %0d: observed %h expected %h", tag, stepno, obs, exp);
        end
    endtask

    // Model: busy for D+1 edges' worth of outputs after release; bank all-zero once clear ends.
    task automatic step(input logic rst, input logic we, input logic [AW-1:0] wa,
                        input logic [W-1:0] wd, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        logic wr1, wr0;
        rst_n    = rst;
        b1.regen = we;
        b1.wa    = wa;
        b1.wd    = wd;
        b1.rr1   = r1;
        b1.rr2   = r2;
        @(posedge clk);
        stepno++;
        if (!rst) begin
            edges_since_rst = 0;
            {e11, e21, e10, e20} = '0;
        end else if (edges_since_rst <= D) begin
            edges_since_rst++;
            {e11, e21, e10, e20} = '0;
            if (edges_since_rst == D + 1) begin
                for (int i = 0; i < D; i++) begin
                    m1[i] = '0;
                    m0[i] = '0;
                end
            end
        end else begin
            wr1 = we && (wa != 0);
            wr0 = we;
            e11 = (r1 == 0) ? '0 : (BYP && wr1 && wa == r1) ? wd : m1[r1];
            e21 = (r2 == 0) ? '0 : (BYP && wr1 && wa == r2) ? wd : m1[r2];
            e10 = (BYP && wr0 && wa == r1) ? wd : m0[r1];
            e20 = (BYP && wr0 && wa == r2) ? wd : m0[r2];
            if (wr1) m1[wa] = wd;
            if (wr0) m0[wa] = wd;
        end
        ebusy = !rst || (edges_since_rst <= D);
        #1;
        chk("busy_z1", {31'b0, b1.busy}, {31'b0, ebusy});
        chk("busy_z0", {31'b0, b0.busy}, {31'b0, ebusy});
        chk("dr1_z1", b1.dr1, e11);
        chk("dr2_z1", b1.dr2, e21);
        chk("dr1_z0", b0.dr1, e10);
        chk("dr2_z0", b0.dr2, e20);
    endtask

    task automatic rstep(input logic rst);
        logic [AW-1:0] wa, r1, r2;
        wa = AW'($urandom_range(0, D - 1));
        r1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, D - 1));
        r2 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, D - 1));
        step(rst, 1'($urandom_range(0, 1)), wa, $urandom, r1, r2);
    endtask

    initial begin
        rst_n = 1'b0;
        b1.regen = 1'b0;
        b1.wa = '0;
        b1.wd = '0;
        b1.rr1 = '0;
        b1.rr2 = '0;
        edges_since_rst = 0;

        // Reset held 3 cycles with writes attempted.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 5'd9, 32'h5555_5555, 5'd9, 5'd9);

        // Clear sequence with random traffic; write to r3 mid-clear must be lost.
        for (int i = 0; i < D + 1; i++) begin
            if (i == 5) step(1'b1, 1'b1, 5'd3, 32'h0000_00AA, 5'd3, 5'd3);
            else        rstep(1'b1);
        end

        // Every register reads zero after the clear.
        for (int i = 0; i < D; i++) step(1'b1, 1'b0, '0, '0, AW'(i), AW'(D - 1 - i));

        // Write then read on both ports.
        step(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd1, 5'd2);
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);

        // Same-edge write/read of r7, then held read.
        step(1'b1, 1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd6);
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);

        // Write to address 0 with same-edge read of 0.
        step(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

        for (int i = 0; i < 300; i++) rstep(1'b1);

        // Reset in READY with a write pending, then reset again at clear index 10.
        step(1'b0, 1'b1, 5'd9, 32'hCAFE_F00D, 5'd9, 5'd9);
        for (int i = 0; i < 10; i++) rstep(1'b1);
        step(1'b0, 1'b0, '0, '0, '0, '0);
        for (int i = 0; i < D + 1; i++) rstep(1'b1);
        for (int i = 0; i < D; i++) step(1'b1, 1'b0, '0, '0, AW'(i), AW'(i));
        for (int i = 0; i < 100; i++) rstep(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/register_bank.md
# register_bank

Parametrised, clocked general-purpose register bank for the processor datapath: one synchronous write port, two registered read ports, hardware clear sequence after reset, optional same-cycle write-to-read forwarding. Replaces the fixed 32×32 combinational bank between the instruction decoder (read addresses) and the writeback stage (write data).

## Interface
- `WIDTH`, 32, data width in bits
- `DEPTH`, 32, number of registers; power of two, ≥ 2
- `AW`, `$clog2(DEPTH)`, address width (derived, not overridden)
- `ZERO_REG`, 1, when 1 register 0 always reads zero and ignores writes
- `clk`  input  1  single clock, all state on rising edge
- `rst_n`  input  1  reset, synchronous, active-low
- `regen`  input  1  write enable
- `wa`  input  AW  write address
- `wd`  input  WIDTH  write data
- `rr1`  input  AW  read address, port 1
- `rr2`  input  AW  read address, port 2
- `dr1`  output  WIDTH  read data, port 1 (registered)
- `dr2`  output  WIDTH  read data, port 2 (registered)
- `busy`  output  1  high while clear sequence runs; writes ignored, reads return 0

## Operation
- FSM states: CLEAR, READY.
- `rst_n` low at an edge: state←CLEAR, clear index←0, `dr1`/`dr2`←0, `busy`←1.
- CLEAR: each cycle writes 0 to bank[index], index increments; after writing index DEPTH−1, state←READY, `busy`←0 on the following edge. Clear takes exactly DEPTH cycles after `rst_n` goes high.
- CLEAR: `regen` ignored; `dr1`/`dr2` load 0.
- READY: if `regen`=1 and not (ZERO_REG=1 and `wa`=0), bank[`wa`]←`wd` on the edge.
- READY: each edge `dr1`←bank[`rr1`], `dr2`←bank[`rr2`] (value before this edge's write, unless forwarding enabled).
- ZERO_REG=1: read of address 0 returns 0 regardless of contents or forwarding.
- Both read ports may address the same register; both return the same value.
- Reset asserted mid-CLEAR: index restarts at 0, full DEPTH-cycle clear repeats.
- Reset asserted in READY with `regen`=1: write dropped.

## Timing
- Write latency: data visible at `dr*` on the edge after the write edge when read address held (2 edges from write request to output, without forwarding).
- Read latency: 1 cycle, address at edge N → data on `dr*` after edge N.
- Reset values: `dr1`=0, `dr2`=0, `busy`=1; bank contents undefined until CLEAR completes.
- `busy` falls DEPTH cycles after the first edge with `rst_n`=1.
- No combinational path from any input to any output.

## Configuration
- `REGISTER_BANK_BYPASS_EN` defined: in READY, if `regen`=1, `wa`=`rr*`, and write is not suppressed by ZERO_REG, `dr*` loads `wd` on the same edge (write-to-read forwarding; read-after-write latency 1 cycle).
- Undefined: `dr*` loads the old bank contents in that case; new value appears one cycle later.
- No other behaviour changes with the macro.

## Structure
- Shared package `register_bank_pkg`: state enum (CLEAR, READY), default `WIDTH`/`DEPTH` constants used by datapath instances.
- One sub-module natural: `register_bank_clear_ctrl` (FSM + clear index counter, outputs `busy`, clear address, clear write strobe); storage, write mux and read registers stay in the top.

## Test plan
- Reset held 3 cycles then released, DEPTH=32 → `busy`=1 for exactly 32 cycles, `dr1`=`dr2`=0 throughout, all 32 registers read 0 afterwards.
- In READY write `wa`=5 `wd`=0xDEADBEEF, next cycle `rr1`=`rr2`=5 → both ports 0xDEADBEEF one cycle later.
- Same-edge write `wa`=7 `wd`=0x12345678 with `rr1`=7 → `dr1`=0x12345678 with macro defined, old value (0) without; next cycle 0x12345678 in both builds.
- ZERO_REG=1, write `wa`=0 `wd`=0xFFFFFFFF, read `rr1`=0 → `dr1`=0 (also with forwarding enabled); ZERO_REG=0 → `dr1`=0xFFFFFFFF.
- `regen`=1 `wa`=3 `wd`=0xAA during CLEAR → write dropped, register 3 reads 0 after `busy` falls.
- Reset reasserted at clear index 10 → `busy` stays high, clear restarts, `busy` falls 32 cycles after second release.
